// File: rtl/ps2_mouse_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ps2_mouse_tracker
// Brief    : PS/2 packet assembler and clamped cursor tracker.
//            Optional macro PS2_WHEEL_EN enables 4-byte IntelliMouse packets.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_mouse_tracker #(
    parameter int COORD_W        = 11,
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int SPEED_SHIFT    = 1,
    parameter int TIMEOUT_CYCLES = 150000,
    parameter int DROP_OVERFLOW  = 1
) (
    input  logic               CLOCK,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               M1,
    output logic               M2,
    output logic               M3,
    output logic [COORD_W-1:0] mouseX,
    output logic [COORD_W-1:0] mouseY,
    output logic               packet_strobe,
    output logic               sync_error
`ifdef PS2_WHEEL_EN
    ,
    output logic signed [7:0]  wheelPos,
    output logic               M4,
    output logic               M5
`endif
);

    localparam int c_SUM_W = COORD_W + SPEED_SHIFT + 2;
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]        c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic signed [c_SUM_W-1:0] c_X_MAX   = c_SUM_W'(SCREEN_W - 1);
    localparam logic signed [c_SUM_W-1:0] c_Y_MAX   = c_SUM_W'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        ST_B0    = 3'd0,
        ST_B1    = 3'd1,
        ST_B2    = 3'd2,
        ST_B3    = 3'd3,
        ST_APPLY = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_idle_cnt;
    logic [2:0]           r_btn;
    logic                 r_xs, r_ys, r_xo, r_yo;
    logic [7:0]           r_xbyte, r_ybyte;
    logic [COORD_W-1:0]   w_new_x, w_new_y;
    logic                 w_timeout;

    // Delta decode, scale and clamp for one axis; neg selects subtraction (Y is up-positive).
    function automatic logic [COORD_W-1:0] f_axis(
        input logic [COORD_W-1:0]        pos,
        input logic                      sgn,
        input logic [7:0]                mag,
        input logic                      ovf,
        input logic                      neg,
        input logic signed [c_SUM_W-1:0] max
    );
        logic signed [8:0]         d;
        logic signed [c_SUM_W-1:0] sd;
        logic signed [c_SUM_W-1:0] base;
        logic signed [c_SUM_W-1:0] sum;
        d = $signed({sgn, mag});
        if (ovf && DROP_OVERFLOW == 0)
            d = sgn ? 9'h100 : 9'h0FF;
        sd   = c_SUM_W'(d) <<< SPEED_SHIFT;
        base = $signed({{(c_SUM_W-COORD_W){1'b0}}, pos});
        sum  = neg ? (base - sd) : (base + sd);
        if (ovf && DROP_OVERFLOW != 0)
            return pos;
        else if (sum[c_SUM_W-1])
            return '0;
        else if (sum > max)
            return COORD_W'(max);
        else
            return sum[COORD_W-1:0];
    endfunction

    always_comb begin
        w_new_x   = f_axis(mouseX, r_xs, r_xbyte, r_xo, 1'b0, c_X_MAX);
        w_new_y   = f_axis(mouseY, r_ys, r_ybyte, r_yo, 1'b1, c_Y_MAX);
        w_timeout = (r_idle_cnt == c_TIMEOUT);
    end

`ifdef PS2_WHEEL_EN
    logic [5:0] r_zbyte;
    logic [8:0] w_wheel_sum;
    logic [7:0] w_wheel_next;

    always_comb begin
        w_wheel_sum  = {wheelPos[7], wheelPos} + {{5{r_zbyte[3]}}, r_zbyte[3:0]};
        w_wheel_next = w_wheel_sum[7:0];
        if (w_wheel_sum[8] != w_wheel_sum[7])
            w_wheel_next = w_wheel_sum[8] ? 8'h80 : 8'h7F;
    end
`endif

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_B0;
            r_idle_cnt    <= '0;
            r_btn         <= '0;
            r_xs          <= 1'b0;
            r_ys          <= 1'b0;
            r_xo          <= 1'b0;
            r_yo          <= 1'b0;
            r_xbyte       <= '0;
            r_ybyte       <= '0;
            M1            <= 1'b0;
            M2            <= 1'b0;
            M3            <= 1'b0;
            mouseX        <= COORD_W'(SCREEN_W / 2);
            mouseY        <= COORD_W'(SCREEN_H / 2);
            packet_strobe <= 1'b0;
            sync_error    <= 1'b0;
`ifdef PS2_WHEEL_EN
            r_zbyte       <= '0;
            wheelPos      <= '0;
            M4            <= 1'b0;
            M5            <= 1'b0;
`endif
        end else begin
            packet_strobe <= 1'b0;
            sync_error    <= 1'b0;

            if (rx_valid || r_state == ST_B0)
                r_idle_cnt <= '0;
            else
                r_idle_cnt <= r_idle_cnt + 1'b1;

            if (r_state == ST_APPLY) begin
                M1     <= r_btn[0];
                M2     <= r_btn[1];
                M3     <= r_btn[2];
                mouseX <= w_new_x;
                mouseY <= w_new_y;
`ifdef PS2_WHEEL_EN
                wheelPos <= w_wheel_next;
                M4       <= r_zbyte[4];
                M5       <= r_zbyte[5];
`endif
            end

            case (r_state)
                // APPLY shares the status-byte rules so a back-to-back byte is not lost.
                ST_B0, ST_APPLY: begin
                    r_state <= ST_B0;
                    if (rx_valid) begin
                        if (rx_data[3]) begin
                            r_btn   <= rx_data[2:0];
                            r_xs    <= rx_data[4];
                            r_ys    <= rx_data[5];
                            r_xo    <= rx_data[6];
                            r_yo    <= rx_data[7];
                            r_state <= ST_B1;
                        end else begin
                            sync_error <= 1'b1;
                        end
                    end
                end
                ST_B1: begin
                    if (rx_valid) begin
                        r_xbyte <= rx_data;
                        r_state <= ST_B2;
                    end else if (w_timeout) begin
                        r_state <= ST_B0;
                    end
                end
                ST_B2: begin
                    if (rx_valid) begin
                        r_ybyte <= rx_data;
`ifdef PS2_WHEEL_EN
                        r_state <= ST_B3;
`else
                        r_state       <= ST_APPLY;
                        packet_strobe <= 1'b1;
`endif
                    end else if (w_timeout) begin
                        r_state <= ST_B0;
                    end
                end
`ifdef PS2_WHEEL_EN
                ST_B3: begin
                    if (rx_valid) begin
                        r_zbyte       <= rx_data[5:0];
                        r_state       <= ST_APPLY;
                        packet_strobe <= 1'b1;
                    end else if (w_timeout) begin
                        r_state <= ST_B0;
                    end
                end
`endif
                default: r_state <= ST_B0;
            endcase
        end
    end

endmodule
`default_nettype wire
